// File: rtl/sym_fir_param.sv
// Symmetric odd-length FIR with a double-buffered coefficient bank.
// Output saturation is enabled by defining SYM_FIR_SAT_EN.
module sym_fir_param #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int NUM_TAPS  = 11,
  parameter int OUT_SHIFT = 14,
  parameter int OUT_W     = 16
) (
  input  logic                  pClk,
  input  logic                  pRst,
  input  logic                  pInValid,
  input  logic [DATA_W-1:0]     pFilterIn,
  input  logic                  pCoefWe,
  input  logic [$clog2((NUM_TAPS+1)/2)-1:0] pCoefAddr,
  input  logic [COEF_W-1:0]     pCoefData,
  input  logic                  pCoefCommit,
  output logic                  pOutValid,
  output logic [OUT_W-1:0]      pFilterOut
);

  localparam int NUM_COEF = (NUM_TAPS + 1) / 2;
  localparam int MID      = NUM_COEF - 1;
  localparam int ADDR_W   = $clog2(NUM_COEF);
  localparam int PRE_W    = DATA_W + 1;
  localparam int PROD_W   = PRE_W + COEF_W;
  localparam int ACC_W    = PROD_W + $clog2(NUM_COEF);

  logic signed [DATA_W-1:0] dly [NUM_TAPS-1];
  logic signed [DATA_W-1:0] tap [NUM_TAPS];

  logic signed [COEF_W-1:0] shd_bank [NUM_COEF];
  logic signed [COEF_W-1:0] act_bank [NUM_COEF];

  logic signed [PRE_W-1:0]  pre_d  [NUM_COEF];
  logic signed [PRE_W-1:0]  pre_q  [NUM_COEF];
  logic signed [PROD_W-1:0] prod_q [NUM_COEF];
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  sh;
  logic [OUT_W-1:0]         out_d;

  logic v1;
  logic v2;
  logic v3;

  // tap[j] is x[n-j]: the live input plus the delay line
  always_comb begin
    tap[0] = $signed(pFilterIn);
    for (int j = 1; j < NUM_TAPS; j++) begin
      tap[j] = dly[j-1];
    end
  end

  always_comb begin
    for (int k = 0; k < MID; k++) begin
      pre_d[k] = {tap[k][DATA_W-1], tap[k]}
               + {tap[NUM_TAPS-1-k][DATA_W-1],
                  tap[NUM_TAPS-1-k]};
    end
    pre_d[MID] = {tap[MID][DATA_W-1], tap[MID]};
  end

  always_ff @(posedge pClk or posedge pRst) begin
    if (pRst) begin
      for (int j = 0; j < NUM_TAPS-1; j++) begin
        dly[j] <= '0;
      end
    end else if (pInValid) begin
      dly[0] <= pFilterIn;
      for (int j = 1; j < NUM_TAPS-1; j++) begin
        dly[j] <= dly[j-1];
      end
    end
  end

  // commit samples the shadow before any same-edge write lands
  always_ff @(posedge pClk or posedge pRst) begin
    if (pRst) begin
      for (int k = 0; k < NUM_COEF; k++) begin
        shd_bank[k] <= '0;
        act_bank[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_COEF; k++) begin
        if (pCoefCommit) begin
          act_bank[k] <= shd_bank[k];
        end
        if (pCoefWe && pCoefAddr == ADDR_W'(k)) begin
          shd_bank[k] <= pCoefData;
        end
      end
    end
  end

  always_comb begin
    acc_d = '0;
    for (int k = 0; k < NUM_COEF; k++) begin
      acc_d = acc_d + ACC_W'(prod_q[k]);
    end
  end

  assign sh = acc_q >>> OUT_SHIFT;

`ifdef SYM_FIR_SAT_EN
  logic [ACC_W-OUT_W:0] hi;
  logic                 ovf;

  assign hi  = sh[ACC_W-1:OUT_W-1];
  assign ovf = !((&hi) || !(|hi));

  always_comb begin
    out_d = sh[OUT_W-1:0];
    if (ovf) begin
      out_d = sh[ACC_W-1]
            ? {1'b1, {(OUT_W-1){1'b0}}}
            : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  assign out_d = sh[OUT_W-1:0];
`endif

  always_ff @(posedge pClk or posedge pRst) begin
    if (pRst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      acc_q      <= '0;
      pOutValid  <= 1'b0;
      pFilterOut <= '0;
      for (int k = 0; k < NUM_COEF; k++) begin
        pre_q[k]  <= '0;
        prod_q[k] <= '0;
      end
    end else begin
      v1        <= pInValid;
      v2        <= v1;
      v3        <= v2;
      pOutValid <= v3;
      for (int k = 0; k < NUM_COEF; k++) begin
        if (pInValid) begin
          pre_q[k] <= pre_d[k];
        end
        if (v1) begin
          prod_q[k] <= PROD_W'(pre_q[k])
                     * PROD_W'(act_bank[k]);
        end
      end
      if (v2) begin
        acc_q <= acc_d;
      end
      if (v3) begin
        pFilterOut <= out_d;
      end
    end
  end

endmodule

// File: tb/tb_sym_fir_param.sv
// Bench for sym_fir_param: behavioural model plus directed/random scenarios.
// Build with SYM_FIR_SAT_EN defined to cover the saturating variant.
module tb_sym_fir_param;

  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int NUM_TAPS  = 11;
  localparam int OUT_SHIFT = 14;
  localparam int OUT_W     = 16;
  localparam int NUM_COEF  = (NUM_TAPS + 1) / 2;
  localparam int ADDR_W    = $clog2(NUM_COEF);

  logic              pClk;
  logic              pRst;
  logic              pInValid;
  logic [DATA_W-1:0] pFilterIn;
  logic              pCoefWe;
  logic [ADDR_W-1:0] pCoefAddr;
  logic [COEF_W-1:0] pCoefData;
  logic              pCoefCommit;
  logic              pOutValid;
  logic [OUT_W-1:0]  pFilterOut;

  sym_fir_param #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_TAPS(NUM_TAPS),
    .OUT_SHIFT(OUT_SHIFT), .OUT_W(OUT_W)
  ) dut (
    .pClk(pClk), .pRst(pRst), .pInValid(pInValid),
    .pFilterIn(pFilterIn), .pCoefWe(pCoefWe),
    .pCoefAddr(pCoefAddr), .pCoefData(pCoefData),
    .pCoefCommit(pCoefCommit), .pOutValid(pOutValid),
    .pFilterOut(pFilterOut)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  // model state: sample history (newest first), banks, in-flight results
  int     hist[$];
  int     act_m[NUM_COEF];
  int     sh_m[NUM_COEF];
  int     pend_t[$];
  longint pend_y[$];
  int     outs[$];
  int     e;
  int     n_cmp;
  int     n_fail;
  logic signed [OUT_W-1:0] last_out;

  function automatic longint hx(int j);
    return (j < hist.size()) ? longint'(hist[j]) : 64'sd0;
  endfunction

  function automatic longint fir_y();
    longint y;
    y = 0;
    for (int k = 0; k < NUM_COEF-1; k++)
      y += longint'(act_m[k]) * (hx(k) + hx(NUM_TAPS-1-k));
    y += longint'(act_m[NUM_COEF-1]) * hx((NUM_TAPS-1)/2);
    return y;
  endfunction

  function automatic logic signed [OUT_W-1:0] scale(longint y);
    longint s;
    longint mx;
    mx = (longint'(1) <<< (OUT_W-1)) - 1;
    s = y >>> OUT_SHIFT;
`ifdef SYM_FIR_SAT_EN
    if (s > mx) s = mx;
    else if (s < -mx - 1) s = -mx - 1;
`endif
    return s[OUT_W-1:0];
  endfunction

  function automatic int rnd16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  task automatic model_reset();
    hist.delete();
    pend_t.delete();
    pend_y.delete();
    for (int k = 0; k < NUM_COEF; k++) begin
      act_m[k] = 0;
      sh_m[k] = 0;
    end
    last_out = '0;
  endtask

  task automatic idle_inputs();
    pInValid = 1'b0;
    pFilterIn = '0;
    pCoefWe = 1'b0;
    pCoefAddr = '0;
    pCoefData = '0;
    pCoefCommit = 1'b0;
  endtask

  // one clock: drive, advance model, check outputs
  task automatic cyc(input bit v, input int d, input bit we = 1'b0,
                     input int a = 0, input int cd = 0,
                     input bit cm = 1'b0);
    bit ev;
    logic signed [OUT_W-1:0] eo;
    pInValid = v;
    pFilterIn = DATA_W'(d);
    pCoefWe = we;
    pCoefAddr = ADDR_W'(a);
    pCoefData = COEF_W'(cd);
    pCoefCommit = cm;
    @(posedge pClk);
    e++;
    if (pend_t.size() > 0 && pend_t[pend_t.size()-1] == e - 1)
      pend_y[pend_y.size()-1] = fir_y();
    if (cm) act_m = sh_m;
    if (we && a < NUM_COEF) sh_m[a] = cd;
    if (v) begin
      hist.push_front(d);
      if (hist.size() > NUM_TAPS) void'(hist.pop_back());
      pend_t.push_back(e);
      pend_y.push_back(0);
    end
    ev = 1'b0;
    eo = last_out;
    if (pend_t.size() > 0 && pend_t[0] == e - 3) begin
      ev = 1'b1;
      eo = scale(pend_y[0]);
      void'(pend_t.pop_front());
      void'(pend_y.pop_front());
    end
    #1;
    n_cmp++;
    if (pOutValid !== ev) begin
      n_fail++;
      $display("FAIL valid edge=%0d got %b want %b", e, pOutValid, ev);
    end
    n_cmp++;
    if (pFilterOut !== eo) begin
      n_fail++;
      $display("FAIL out edge=%0d got %0d want %0d",
               e, $signed(pFilterOut), eo);
    end
    last_out = eo;
    if (pOutValid === 1'b1) outs.push_back(int'($signed(pFilterOut)));
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    pRst = 1'b1;
    #1;
    n_cmp++;
    if (pOutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got %b want 0", pOutValid);
    end
    n_cmp++;
    if (pFilterOut !== '0) begin
      n_fail++;
      $display("FAIL rst_out got %0d want 0", $signed(pFilterOut));
    end
    model_reset();
    @(posedge pClk);
    e++;
    #1;
    pRst = 1'b0;
  endtask

  task automatic set_c5_delay();
    cyc(0, 0, 1, 5, 16384);
    cyc(0, 0, 0, 0, 0, 1);
  endtask

  task automatic chk_outs(input string nm, input int idx, input int want);
    n_cmp++;
    if (outs.size() <= idx || outs[idx] !== want) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0d want %0d", nm, idx,
               (outs.size() > idx) ? outs[idx] : -99999, want);
    end
  endtask

  task automatic chk_count(input string nm, input int want);
    n_cmp++;
    if (outs.size() != want) begin
      n_fail++;
      $display("FAIL %s_count got %0d want %0d", nm, outs.size(), want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    outs.delete();
    repeat (20) cyc(1, 1000);
    repeat (4) cyc(0, 0);
    chk_count("zero", 20);
    for (int i = 0; i < 20; i++) chk_outs("zero", i, 0);
  endtask

  task automatic test_pure_delay();
    do_reset();
    set_c5_delay();
    outs.delete();
    for (int i = 1; i <= 20; i++) cyc(1, i);
    repeat (4) cyc(0, 0);
    chk_count("delay", 20);
    for (int i = 0; i < 20; i++) chk_outs("delay", i, (i < 5) ? 0 : i - 4);
  endtask

  task automatic test_async_reset();
    do_reset();
    set_c5_delay();
    for (int i = 1; i <= 10; i++) cyc(1, i * 100);
    do_reset();
    set_c5_delay();
    outs.delete();
    for (int i = 1; i <= 10; i++) cyc(1, 7000 + i);
    repeat (4) cyc(0, 0);
    chk_count("rst_hist", 10);
    for (int i = 0; i < 5; i++) chk_outs("rst_hist", i, 0);
    chk_outs("rst_hist", 5, 7001);
  endtask

  task automatic test_impulse();
    int imp[11];
    do_reset();
    for (int k = 0; k < NUM_COEF; k++) cyc(0, 0, 1, k, 1000 * (k + 1));
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 11; i++) imp[i] = 1000 * ((i <= 5) ? i + 1 : 11 - i);
    outs.delete();
    cyc(1, 16384);
    repeat (14) cyc(1, 0);
    repeat (4) cyc(0, 0);
    chk_count("impulse", 15);
    for (int i = 0; i < 15; i++) chk_outs("impulse", i, (i < 11) ? imp[i] : 0);
  endtask

  task automatic test_gapped();
    do_reset();
    set_c5_delay();
    outs.delete();
    for (int i = 1; i <= 20; i++) begin
      cyc(1, i);
      cyc(0, 0);
      cyc(0, 0);
    end
    repeat (4) cyc(0, 0);
    chk_count("gapped", 20);
    for (int i = 0; i < 20; i++) chk_outs("gapped", i, (i < 5) ? 0 : i - 4);
  endtask

  task automatic test_shadow_commit();
    do_reset();
    for (int k = 0; k < NUM_COEF; k++) cyc(0, 0, 1, k, rnd16());
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      if (i >= 5 && i < 5 + NUM_COEF)
        cyc(1, rnd16(), 1, i - 5, rnd16());
      else if (i == 20)
        cyc(1, rnd16(), 0, 0, 0, 1);
      else if (i == 30)
        cyc(1, rnd16(), 1, 2, rnd16(), 1);
      else
        cyc(1, rnd16());
    end
    repeat (4) cyc(0, 0);
    // same-edge write+commit: the written 8192 stays in shadow only
    do_reset();
    set_c5_delay();
    cyc(0, 0, 1, 5, 8192, 1);
    outs.delete();
    repeat (6) cyc(1, 1000);
    repeat (4) cyc(0, 0);
    chk_outs("same_edge", 5, 1000);
    cyc(0, 0, 0, 0, 0, 1);
    outs.delete();
    repeat (6) cyc(1, 1000);
    repeat (4) cyc(0, 0);
    chk_outs("recommit", 5, 500);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < NUM_COEF; k++) cyc(0, 0, 1, k, 32767);
    cyc(0, 0, 0, 0, 0, 1);
    outs.delete();
    repeat (20) cyc(1, 32767);
    repeat (4) cyc(0, 0);
    chk_count("sat_pos", 20);
`ifdef SYM_FIR_SAT_EN
    chk_outs("sat_pos", 19, 32767);
`endif
    outs.delete();
    repeat (20) cyc(1, -32768);
    repeat (4) cyc(0, 0);
    chk_count("sat_neg", 20);
`ifdef SYM_FIR_SAT_EN
    chk_outs("sat_neg", 19, -32768);
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < NUM_COEF; k++) cyc(0, 0, 1, k, rnd16());
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, rnd16(),
          $urandom_range(0, 7) == 0, $urandom_range(0, 7), rnd16(),
          $urandom_range(0, 15) == 0);
    end
    repeat (4) cyc(0, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    e = 0;
    pRst = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    test_reset();
    test_pure_delay();
    test_async_reset();
    test_impulse();
    test_gapped();
    test_shadow_commit();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
